hilo_div_ctrl: RTL and testbench

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

---
 rtl/hilo_div_ctrl_if.sv | 30 +++
 rtl/hilo_div_ctrl.sv | 119 +++++++++++
 tb/tb_hilo_div_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hilo_div_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hilo_div_ctrl_if                                          |
// | Brief    : Request/result bundle between pipeline and HI/LO divider. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface hilo_div_ctrl_if #(
   parameter int DW = 32
) ();
   logic          start_i;
   logic          signed_i;
   logic [DW-1:0] opdata1_i;
   logic [DW-1:0] opdata2_i;
   logic          annul_i;
   logic          stall_req_o;
   logic          hilo_we_o;
   logic [DW-1:0] hilo_hi_o;
   logic [DW-1:0] hilo_lo_o;

   modport master (
      output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      input  stall_req_o, hilo_we_o, hilo_hi_o, hilo_lo_o
   );

   modport slave (
      input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      output stall_req_o, hilo_we_o, hilo_hi_o, hilo_lo_o
   );
endinterface
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hilo_div_ctrl                                             |
// | Brief    : Iterative restoring divider feeding the HI/LO register.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hilo_div_ctrl #(
   parameter int DW = 32
) (
   input  wire logic       clk,
   input  wire logic       rst,
   hilo_div_ctrl_if.slave  bus
);
   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_dbz  = 2'd1;
   localparam logic [1:0] c_on   = 2'd2;
   localparam logic [1:0] c_end  = 2'd3;

   logic [1:0]    r_state;
   logic [5:0]    r_cnt;
   logic          r_neg_q;
   logic          r_neg_r;
   logic [DW-1:0] r_quo;
   logic [DW-1:0] r_rem;
   logic [DW-1:0] r_div;
   logic [DW-1:0] r_hi;
   logic [DW-1:0] r_lo;

   logic          w_op1_neg;
   logic          w_op2_neg;
   logic [DW-1:0] w_op1_mag;
   logic [DW-1:0] w_op2_mag;
   logic          w_dbz;
   logic          w_accept;
   logic [DW:0]   w_shift;
   logic [DW:0]   w_diff;
   logic          w_qbit;
   logic [DW-1:0] w_rem_nx;
   logic [DW-1:0] w_quo_nx;
   logic [DW-1:0] w_lo_fix;
   logic [DW-1:0] w_hi_fix;
   logic          w_last;

   assign w_op1_neg = bus.signed_i & bus.opdata1_i[DW-1];
   assign w_op2_neg = bus.signed_i & bus.opdata2_i[DW-1];
   assign w_op1_mag = w_op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
   assign w_op2_mag = w_op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
   assign w_dbz     = (bus.opdata2_i == '0);
   assign w_accept  = (r_state == c_idle) && bus.start_i && !bus.annul_i;

   // Dividend bits shift out of r_quo into the partial remainder; quotient bits shift in behind.
   assign w_shift  = {r_rem, r_quo[DW-1]};
   assign w_diff   = w_shift - {1'b0, r_div};
   assign w_qbit   = ~w_diff[DW];
   assign w_rem_nx = w_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];
   assign w_quo_nx = {r_quo[DW-2:0], w_qbit};
   assign w_lo_fix = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
   assign w_hi_fix = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
   assign w_last   = (r_cnt == 6'(DW - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_accept) begin
                  r_neg_q <= w_op1_neg ^ w_op2_neg;
                  r_neg_r <= w_op1_neg;
                  r_div   <= w_op2_mag;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  // Divide-by-zero reports the raw dividend, so keep it unconverted.
                  r_quo   <= w_dbz ? bus.opdata1_i : w_op1_mag;
                  r_state <= w_dbz ? c_dbz : c_on;
               end
            end
            c_dbz: begin
               if (bus.annul_i) begin
                  r_state <= c_idle;
               end else begin
                  r_lo    <= '1;
                  r_hi    <= r_quo;
                  r_state <= c_end;
               end
            end
            c_on: begin
               if (bus.annul_i) begin
                  r_state <= c_idle;
               end else begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  r_cnt <= r_cnt + 6'd1;
                  if (w_last) begin
                     r_lo    <= w_lo_fix;
                     r_hi    <= w_hi_fix;
                     r_state <= c_end;
                  end
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign bus.stall_req_o = !rst && (w_accept || (r_state == c_dbz) || (r_state == c_on));
   assign bus.hilo_we_o   = !rst && (r_state == c_end) && !bus.annul_i;
   assign bus.hilo_hi_o   = r_hi;
   assign bus.hilo_lo_o   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_hilo_div_ctrl                                          |
// | Brief    : Directed self-checking bench for hilo_div_ctrl.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_hilo_div_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   hilo_div_ctrl_if #(.DW(32)) bus ();

   hilo_div_ctrl #(.DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one divide in cycle 0 and follows it through END and the cycle after.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_end);
      int   cyc;
      logic stall_ok;
      logic [31:0] hold_hi;
      logic [31:0] hold_lo;
      bus.start_i   = 1'b1;
      bus.signed_i  = sgn;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      #1;
      stall_ok = bus.stall_req_o;
      @(posedge clk); #1;
      cyc = 1;
      bus.start_i   = 1'b0;
      bus.signed_i  = ~sgn;
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      while (!bus.hilo_we_o && cyc < 45) begin
         if (!bus.stall_req_o) stall_ok = 1'b0;
         if (cyc == 5) begin
            bus.start_i = 1'b1;
            #1;
         end else begin
            bus.start_i = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.start_i = 1'b0;
      check({tag, " end_cycle"}, cyc, exp_end);
      check({tag, " stall_busy"}, {31'd0, stall_ok}, 32'd1);
      check({tag, " stall_end"}, {31'd0, bus.stall_req_o}, 32'd0);
      check({tag, " hi"}, bus.hilo_hi_o, exp_hi);
      check({tag, " lo"}, bus.hilo_lo_o, exp_lo);
      hold_hi = bus.hilo_hi_o;
      hold_lo = bus.hilo_lo_o;
      // A start presented during END must be ignored.
      bus.start_i   = 1'b1;
      bus.opdata2_i = 32'd1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      #1;
      check({tag, " we_single"}, {31'd0, bus.hilo_we_o}, 32'd0);
      check({tag, " end_start_ignored"}, {31'd0, bus.stall_req_o}, 32'd0);
      check({tag, " hold_hi"}, bus.hilo_hi_o, hold_hi);
      check({tag, " hold_lo"}, bus.hilo_lo_o, hold_lo);
   endtask

   initial begin
      int we_seen;
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      bus.start_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;
      bus.annul_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst hi", bus.hilo_hi_o, 32'd0);
      check("rst lo", bus.hilo_lo_o, 32'd0);
      check("rst we", {31'd0, bus.hilo_we_o}, 32'd0);
      check("rst stall", {31'd0, bus.stall_req_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_div("u100_7",   1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       33);
      do_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      do_div("u-7_2",    1'b0, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 33);
      do_div("dbz",      1'b0, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 2);
      do_div("dbz_neg",  1'b1, 32'h80000001, 32'd0,        32'h80000001, 32'hFFFFFFFF, 2);
      do_div("s_minovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33);
      do_div("s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
      do_div("u5_9",     1'b0, 32'd5,        32'd9,        32'd5,        32'd0,        33);

      // Annul in cycle 10 of the iteration.
      prev_hi = bus.hilo_hi_o;
      prev_lo = bus.hilo_lo_o;
      we_seen = 0;
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (bus.hilo_we_o) we_seen++;
         @(posedge clk); #1;
      end
      bus.annul_i = 1'b1;
      @(posedge clk); #1;
      bus.annul_i = 1'b0;
      #1;
      check("annul stall", {31'd0, bus.stall_req_o}, 32'd0);
      check("annul hi", bus.hilo_hi_o, prev_hi);
      check("annul lo", bus.hilo_lo_o, prev_lo);
      for (int c = 0; c < 40; c++) begin
         if (bus.hilo_we_o) we_seen++;
         @(posedge clk); #1;
      end
      check("annul no_we", we_seen, 32'd0);
      do_div("post_annul", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);

      // Reset in cycle 20 of the iteration, then an immediate new start.
      we_seen = 0;
      bus.start_i   = 1'b1;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 1; c < 20; c++) begin
         if (bus.hilo_we_o) we_seen++;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("mrst hi", bus.hilo_hi_o, 32'd0);
      check("mrst lo", bus.hilo_lo_o, 32'd0);
      check("mrst we", {31'd0, bus.hilo_we_o}, 32'd0);
      check("mrst stall", {31'd0, bus.stall_req_o}, 32'd0);
      check("mrst no_we", we_seen, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
